// File: rtl/leaf_skid_stage_if.sv
// Valid/ready/data handshake bundle used on both sides of the skid stage.
interface leaf_skid_stage_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/leaf_skid_stage.sv
// Two-entry skid buffer (main + skid register) with registered ready and a delivered-beat counter.
// Optional LEAF_SKID_STAGE_PARITY_EN adds out_parity, even parity of the main register.
module leaf_skid_stage #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    leaf_skid_stage_if.slave    upstream,
    leaf_skid_stage_if.master   downstream,
    output logic [CNT_W-1:0]    beat_count
`ifdef LEAF_SKID_STAGE_PARITY_EN
    ,
    output logic                out_parity
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] main_q, main_next;
    logic [WIDTH-1:0] skid_q, skid_next;
    logic             ready_q;
    logic             valid_q;
    logic             accept;
    logic             deliver;

`ifdef LEAF_SKID_STAGE_PARITY_EN
    logic parity_q;

    function automatic logic even_parity(input logic [WIDTH-1:0] value);
        return ^value;
    endfunction

    assign out_parity = parity_q;
`endif

    assign accept           = upstream.valid & ready_q;
    assign deliver          = valid_q & downstream.ready;
    assign upstream.ready   = ready_q;
    assign downstream.valid = valid_q;
    assign downstream.data  = main_q;

    always_comb begin
        state_next = state;
        main_next  = main_q;
        skid_next  = skid_q;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = ONE;
                    main_next  = upstream.data;
                end
            end
            ONE: begin
                case ({accept, deliver})
                    2'b10: begin
                        state_next = TWO;
                        skid_next  = upstream.data;
                    end
                    2'b01: state_next = EMPTY;
                    2'b11: main_next  = upstream.data;
                    default: ;
                endcase
            end
            TWO: begin
                // ready_q is low here, so only the drain side can move
                if (deliver) begin
                    state_next = ONE;
                    main_next  = skid_q;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Ready/valid are computed from the next state so both stay pure flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            main_q     <= '0;
            beat_count <= '0;
`ifdef LEAF_SKID_STAGE_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            ready_q <= (state_next != TWO);
            valid_q <= (state_next != EMPTY);
            main_q  <= main_next;
            if (deliver) begin
                beat_count <= beat_count + CNT_W'(1);
            end
`ifdef LEAF_SKID_STAGE_PARITY_EN
            parity_q <= even_parity(main_next);
`endif
        end
    end

    // Skid contents are only observable after being moved into main, so no reset
    always_ff @(posedge clk) begin
        skid_q <= skid_next;
    end

endmodule

// File: tb/tb_leaf_skid_stage.sv
// Scoreboard bench for leaf_skid_stage: a CNT_W=16 instance and a CNT_W=4 instance share stimulus.
module tb_leaf_skid_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;

    logic [15:0] beat_count;
    logic [3:0]  beat_count4;
`ifdef LEAF_SKID_STAGE_PARITY_EN
    logic        out_parity;
    logic        out_parity4;
`endif

    leaf_skid_stage_if #(.WIDTH(8)) up_if ();
    leaf_skid_stage_if #(.WIDTH(8)) dn_if ();
    leaf_skid_stage_if #(.WIDTH(8)) up4_if ();
    leaf_skid_stage_if #(.WIDTH(8)) dn4_if ();

    assign up_if.valid  = in_valid;
    assign up_if.data   = in_data;
    assign dn_if.ready  = out_ready;
    assign up4_if.valid = in_valid;
    assign up4_if.data  = in_data;
    assign dn4_if.ready = out_ready;

    leaf_skid_stage #(.WIDTH(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .upstream   (up_if.slave),
        .downstream (dn_if.master),
        .beat_count (beat_count)
`ifdef LEAF_SKID_STAGE_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    leaf_skid_stage #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .upstream   (up4_if.slave),
        .downstream (dn4_if.master),
        .beat_count (beat_count4)
`ifdef LEAF_SKID_STAGE_PARITY_EN
        ,
        .out_parity (out_parity4)
`endif
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         model_cnt = 0;
    logic [7:0] sb[$];
    logic       seen_rdy;
    logic       seen_vld;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; handshakes are observed mid-cycle, before the edge that commits them
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        logic [31:0] e;
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        seen_rdy = up_if.ready;
        seen_vld = dn_if.valid;
        e = model_cnt;
        check("beat_count", 32'(beat_count), e & 32'hFFFF);
        check("beat_count4", 32'(beat_count4), e & 32'hF);
        if (in_valid && up_if.ready) sb.push_back(d);
        if (dn_if.valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(dn_if.data), 32'hDEAD);
            end else begin
                check("out_data", 32'(dn_if.data), 32'(sb.pop_front()));
            end
            check("out_data4", 32'(dn4_if.data), 32'(dn_if.data));
            model_cnt++;
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(up_if.ready), 32'd1);
        check("rst_out_valid", 32'(dn_if.valid), 32'd0);
        check("rst_out_data", 32'(dn_if.data), 32'd0);
        check("rst_beat_count", 32'(beat_count), 32'd0);
        check("rst_beat_count4", 32'(beat_count4), 32'd0);
        sb.delete();
        model_cnt = 0;
    endtask

    initial begin
        do_reset();

        // single beat
        step(1'b1, 8'hA5, 1'b1);
        #1;
        check("t1_out_valid", 32'(dn_if.valid), 32'd1);
        check("t1_out_data", 32'(dn_if.data), 32'hA5);
        step(1'b0, 8'hxx, 1'b1);
        step(1'b0, 8'hxx, 1'b1);
        check("t1_count", 32'(model_cnt), 32'd1);
        check("t1_idle_valid", 32'(seen_vld), 32'd0);

        // backpressure fills the skid register
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        #1;
        check("t2_in_ready_low", 32'(up_if.ready), 32'd0);
        step(1'b1, 8'h33, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        #1;
        check("t2_hold_data", 32'(dn_if.data), 32'h11);
        check("t2_hold_valid", 32'(dn_if.valid), 32'd1);
        step(1'b1, 8'h33, 1'b1);
        step(1'b1, 8'h33, 1'b1);
        step(1'b0, 8'hxx, 1'b1);
        step(1'b0, 8'hxx, 1'b1);
        check("t2_drained", 32'(sb.size()), 32'd0);
        check("t2_count", 32'(model_cnt), 32'd4);

        // full throughput
        do_reset();
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 8'(i), 1'b1);
            check("t3_in_ready", 32'(seen_rdy), 32'd1);
            if (i > 0) check("t3_no_bubble", 32'(seen_vld), 32'd1);
        end
        step(1'b0, 8'hxx, 1'b1);
        #1;
        check("t3_beat_count", 32'(beat_count), 32'd100);
        check("t3_sb_empty", 32'(sb.size()), 32'd0);

        // narrow counter wraps
        do_reset();
        for (int i = 0; i < 17; i++) step(1'b1, 8'(i + 8'h40), 1'b1);
        step(1'b0, 8'hxx, 1'b1);
        #1;
        check("t4_wrap4", 32'(beat_count4), 32'd1);
        check("t4_count16", 32'(beat_count), 32'd17);

        // reset while full discards both beats
        do_reset();
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        #1;
        check("t5_full", 32'(up_if.ready), 32'd0);
        do_reset();
        step(1'b1, 8'h5A, 1'b1);
        step(1'b0, 8'hxx, 1'b1);
        step(1'b0, 8'hxx, 1'b1);
        check("t5_only_new", 32'(model_cnt), 32'd1);
        check("t5_sb_empty", 32'(sb.size()), 32'd0);

`ifdef LEAF_SKID_STAGE_PARITY_EN
        do_reset();
        check("t6_rst_parity", 32'(out_parity), 32'd0);
        step(1'b1, 8'h07, 1'b0);
        #1;
        check("t6_parity_07", 32'(out_parity), 32'd1);
        step(1'b0, 8'hxx, 1'b1);
        step(1'b1, 8'h03, 1'b1);
        #1;
        check("t6_parity_03", 32'(out_parity), 32'd0);
        step(1'b0, 8'hxx, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/leaf_skid_stage.md
LEAF_SKID_STAGE -- requirements
Module: leaf_skid_stage

Interface
REQ-001 Parameter WIDTH, default 8, payload width in bits (legal 1..64).
REQ-002 Parameter CNT_W, default 16, width of the delivered-beat counter (legal 4..32).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream offers in_data this cycle.
REQ-006 in_ready  output  1  stage can accept a beat this cycle.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 out_valid  output  1  stage presents out_data.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 out_data  output  WIDTH  payload to downstream.
REQ-011 beat_count  output  CNT_W  number of beats delivered downstream since reset.

Function
REQ-012 Handshake: transfer occurs on a port only in a cycle where valid and ready are both high at the clock edge.
REQ-013 Storage: one main register plus one skid register; capacity exactly 2 beats; strict FIFO order.
REQ-014 States: EMPTY (0 beats), ONE (main full), TWO (main and skid full).
REQ-015 in_ready is a register output, high in EMPTY and ONE, low in TWO; no combinational path from out_ready to in_ready.
REQ-016 out_valid is high in ONE and TWO; out_data always equals the main register.
REQ-017 EMPTY, input beat -> ONE; the beat is visible on out_data the next cycle (latency 1).
REQ-018 ONE: input only -> TWO (beat into skid); output only -> EMPTY; both -> stay ONE with main loaded from in_data.
REQ-019 TWO: output handshake -> ONE with skid moved to main; no input accepted in TWO.
REQ-020 out_data and out_valid hold steady while out_valid is high and out_ready is low.
REQ-021 beat_count increments by 1 per output handshake, wraps from 2^CNT_W-1 to 0, no saturation.
REQ-022 in_valid, in_data ignored when in_ready is low; X on in_data with in_valid low does not propagate to out_data.
REQ-023 Full throughput: sustained in_valid and out_ready both high yields one beat per cycle, no bubbles.

Reset
REQ-024 rst high at a clock edge forces EMPTY: in_ready=1, out_valid=0, out_data=0, beat_count=0.
REQ-025 Reset mid-operation discards stored beats; no handshake is counted in the reset cycle.
REQ-026 First transfer is possible on the first edge after rst deasserts.

Configuration
REQ-027 Macro LEAF_SKID_STAGE_PARITY_EN: when defined, adds output out_parity (1 bit, even parity of out_data, registered alongside the main register, reset 0).
REQ-028 Without LEAF_SKID_STAGE_PARITY_EN the out_parity port and its logic are absent; all other behaviour identical.

Verification
REQ-029 Reset, then in_data=0xA5 valid one cycle, out_ready=1 -> out_valid high next cycle with 0xA5, beat_count=1.
REQ-030 out_ready=0, push 0x11, 0x22 -> in_ready low after second accept; 0x33 held off; release out_ready -> order 0x11, 0x22, 0x33.
REQ-031 Both valid and ready high for 100 cycles with incrementing data 0..99 -> 100 consecutive outputs, no gaps, beat_count=100.
REQ-032 CNT_W=4, deliver 17 beats -> beat_count reads 1.
REQ-033 Stage in TWO, assert rst one cycle -> out_valid=0, in_ready=1, beat_count=0; stored beats never appear.
REQ-034 With LEAF_SKID_STAGE_PARITY_EN, WIDTH=8, send 0x07 -> out_parity=1; send 0x03 -> out_parity=0.
